// File: rtl/wt_arbiter.sv
// wt_arbiter: write-side arbiter sharing one FIFO push port between NUM_REQ requesters.
//
// Requesters are served round-robin, one bounded burst (up to BURST_MAX words) per grant.
// A new burst opens only when neither full nor almost_full is set; an open burst stalls on
// full and ends early when its owner drops req. Each grant costs one idle arbitration cycle.
// A saturating counter tallies push_on_full_error pulses independently of the arbiter.
//
// Ports:
//   wt_clk             write-domain clock, rising edge
//   rst_in_wt          async active-high reset
//   req                per-requester valid
//   req_data           packed words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full, almost_full  FIFO fill flags
//   push_on_full_error FIFO error pulse, counted into err_cnt
//   wt_en, wt_data     push strobe and word to the FIFO
//   gnt                one-hot, set for the owner whose word is consumed this cycle
//   owner              current / most recent burst owner
//   busy               high while a burst is open
//   err_cnt            saturating error count
module wt_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned ERR_W      = 8,
  localparam int unsigned IDX_W     = $clog2(NUM_REQ),
  localparam int unsigned BEAT_W    = $clog2(BURST_MAX) + 1
) (
  input  logic                          wt_clk,
  input  logic                          rst_in_wt,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  input  logic                          almost_full,
  input  logic                          push_on_full_error,
  output logic                          wt_en,
  output logic [DATA_WIDTH-1:0]         wt_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [IDX_W-1:0]              owner,
  output logic                          busy,
  output logic [ERR_W-1:0]              err_cnt
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic               push;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  assign push = (state_q == StBurst) && req[owner_q] && !full;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld && !almost_full && !full) begin
          owner_d = pick;
          beat_d  = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (push) begin
          if (beat_q == BEAT_W'(BURST_MAX - 1)) begin
            last_d  = owner_q;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (!req[owner_q]) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
        // req[owner] && full: stall, beat held
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push_on_full_error && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wt_clk or posedge rst_in_wt) begin
    if (rst_in_wt) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      beat_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Constant-base slice mux keeps the data path free of variable part-selects.
  always_comb begin
    wt_data = req_data[0 +: DATA_WIDTH];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        wt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    gnt          = '0;
    gnt[owner_q] = push;
  end

  assign wt_en   = push;
  assign owner   = owner_q;
  assign busy    = (state_q == StBurst);
  assign err_cnt = err_cnt_q;

endmodule
